// File: rtl/indep_env_pkg.sv
// Shared types for the indep controller environment: signal widths, the
// responder state encoding and the capture entry layout.
package indep_env_pkg;

  localparam int XW     = 6;   // controller condition inputs x1..x6
  localparam int YW     = 23;  // controller outputs y1..y23
  localparam int STEP_W = 4;   // step index carried by a capture entry (16-entry script)

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  typedef struct packed {
    logic [STEP_W-1:0] step;
    logic [YW-1:0]     y;
  } cap_entry_t;

endpackage

// File: rtl/indep_cap_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module indep_cap_fifo #(
  parameter int CAP_DEPTH = 16,
  parameter int W         = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(CAP_DEPTH);

  logic [W-1:0]  r_mem [CAP_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(CAP_DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage is deliberately left out of reset; an empty FIFO never exposes it.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/indep_stim_responder.sv
// Script-driven stimulus for the indep controller: plays x from a step script
// and captures the controller's y once per step into a pop-able FIFO.
module indep_stim_responder
  import indep_env_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CAP_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [XW-1:0]              cfg_xvec,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     run_len,
  output logic [XW-1:0]              x,
  input  logic [YW-1:0]              y,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       cap_valid,
  input  logic                       cap_ready,
  output logic [YW-1:0]              cap_data,
  output logic [$clog2(DEPTH)-1:0]   cap_step
);

  localparam int AW = $clog2(DEPTH);

  logic [XW-1:0] r_script [DEPTH];
  state_t        r_state;
  logic [AW-1:0] r_i;
  logic [AW:0]   r_len;
  logic [XW-1:0] r_x;
  logic          r_busy;
  logic          r_done;
  logic          r_overflow;
  logic [YW-1:0] r_y_hold;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_i_next_ext;
  cap_entry_t    w_push_entry;
  cap_entry_t    w_head;

  always_ff @(posedge clk) begin
    if (cfg_we && !r_busy) r_script[cfg_addr] <= cfg_xvec;
  end

  // The controller moves on the falling edge, so y here is the Mealy output for the current x.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_y_hold <= '0;
    else     r_y_hold <= y;
  end

  // Every RUN edge closes the current step, so the last capture lands on the
  // edge that leaves RUN and busy spans exactly run_len cycles.
  assign w_push            = (r_state == RUN);
  assign w_pop             = !w_empty && cap_ready;
  assign w_i_next_ext      = {1'b0, r_i} + (AW+1)'(1);
  assign w_push_entry.step = STEP_W'(r_i);
  assign w_push_entry.y    = r_y_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_len      <= '0;
      r_x        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      case (r_state)
        RUN: begin
          if (w_i_next_ext < r_len) begin
            r_i <= r_i + AW'(1);
            r_x <= r_script[r_i + AW'(1)];
          end else begin
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end
        end
        // FIN is the done cycle; it already accepts start so runs can chain.
        default: begin
          r_state <= IDLE;
          if (start) begin
            if (run_len != '0) begin
              r_len      <= run_len;
              r_i        <= '0;
              r_x        <= r_script[0];
              r_busy     <= 1'b1;
              r_overflow <= 1'b0;
              r_state    <= RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  indep_cap_fifo #(
    .CAP_DEPTH (CAP_DEPTH),
    .W         ($bits(cap_entry_t))
  ) u_cap_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign x         = r_x;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign cap_valid = !w_empty;
  assign cap_data  = w_head.y;
  assign cap_step  = AW'(w_head.step);

endmodule
